// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - repeating serial bit-pattern transmitter with gap and abort
module seq_pattern_tx #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
    parameter int                 GAP     = 1,
    parameter int                 CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
    // The gap counter counts down to zero, so it is loaded with GAP-1.
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [IDX_W-1:0]   bit_idx;
    logic [3:0]         gap_cnt;
    logic [CNT_W-1:0]   remaining;
    // Holds the pattern still to be sent; its MSB is the bit on dout this cycle.
    logic [PAT_LEN-1:0] shreg;

    logic in_flight;
    assign in_flight = (state == S_SEND) || (state == S_GAP);

    // State, bit index, gap counter, repetition count and pattern shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            remaining <= '0;
            shreg     <= '0;
        end else if (abort && in_flight) begin
            state     <= S_IDLE;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            remaining <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (rep != '0) begin
                            remaining <= rep;
                            bit_idx   <= '0;
                            shreg     <= PATTERN;
                            state     <= S_SEND;
                        end else begin
                            state     <= S_DONE;
                        end
                    end
                end
                S_SEND: begin
                    if (bit_idx == LAST_IDX) begin
                        remaining <= remaining - 1'b1;
                        bit_idx   <= '0;
                        // Reload now so a back-to-back repetition starts cleanly.
                        shreg     <= PATTERN;
                        if (remaining == CNT_W'(1)) begin
                            state <= S_DONE;
                        end else if (GAP > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        shreg   <= shreg << 1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    bit_idx   <= '0;
                    gap_cnt   <= '0;
                    remaining <= '0;
                    shreg     <= '0;
                end
            endcase
        end
    end

    // Outputs decode only registered state, never the start/rep/abort inputs.
    assign dout_valid = (state == S_SEND);
    assign dout       = (state == S_SEND) & shreg[PAT_LEN-1];
    assign busy       = in_flight;
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed vector bench for seq_pattern_tx
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [3:0] rep = 4'd0;
    logic       abort = 1'b0;
    logic       dout0, vld0, busy0, done0;
    logic       dout1, vld1, busy1, done1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_pattern_tx u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .rep(rep), .abort(abort),
        .dout(dout0), .dout_valid(vld0), .busy(busy0), .done(done0)
    );

    seq_pattern_tx #(.GAP(0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .rep(rep), .abort(abort),
        .dout(dout1), .dout_valid(vld1), .busy(busy1), .done(done1)
    );

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] rep;
        int         ncyc;
        logic [31:0] vld;
        logic [31:0] dat;
        logic [31:0] bsy;
        logic [31:0] dn;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int dut, input int cyc,
                            input logic e_dat, input logic e_vld, input logic e_bsy, input logic e_dn);
        if (dut == 0) begin
            chk({name, ".dout"}, cyc, dout0, e_dat);
            chk({name, ".valid"}, cyc, vld0, e_vld);
            chk({name, ".busy"}, cyc, busy0, e_bsy);
            chk({name, ".done"}, cyc, done0, e_dn);
        end else begin
            chk({name, ".dout"}, cyc, dout1, e_dat);
            chk({name, ".valid"}, cyc, vld1, e_vld);
            chk({name, ".busy"}, cyc, busy1, e_bsy);
            chk({name, ".done"}, cyc, done1, e_dn);
        end
    endtask

    task automatic pulse_start(input int dut, input logic [3:0] r);
        rep = r;
        if (dut == 0) start0 = 1'b1; else start1 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        // Changing rep while busy must not matter.
        rep = ~r;
    endtask

    // Time runs left to right in each expected literal: cycle k is bit ncyc-1-k.
    task automatic run_vec(input vec_t v);
        pulse_start(v.dut, v.rep);
        for (int k = 0; k < v.ncyc; k++) begin
            chk_outs(v.name, v.dut, k, v.dat[v.ncyc-1-k], v.vld[v.ncyc-1-k],
                     v.bsy[v.ncyc-1-k], v.dn[v.ncyc-1-k]);
            step();
        end
    endtask

    initial begin
        vecs[0] = '{"rep1",      0, 4'd1, 7,  32'b1111100, 32'b1011000,
                    32'b1111100, 32'b0000010};
        vecs[1] = '{"rep2_gap1", 0, 4'd2, 13, 32'b1111101111100, 32'b1011001011000,
                    32'b1111111111100, 32'b0000000000010};
        vecs[2] = '{"rep3_gap0", 1, 4'd3, 17, 32'b11111111111111100, 32'b10110101101011000,
                    32'b11111111111111100, 32'b00000000000000010};
        vecs[3] = '{"rep0",      0, 4'd0, 3,  32'b000, 32'b000, 32'b000, 32'b100};
        vecs[4] = '{"rep1_gap0", 1, 4'd1, 7,  32'b1111100, 32'b1011000,
                    32'b1111100, 32'b0000010};

        reset = 1'b1;
        step();
        step();
        chk_outs("reset_d0", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("reset_d1", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Re-pulse start during the first repetition, then abort at bit 3 of the second.
        pulse_start(0, 4'd2);
        for (int k = 0; k < 10; k++) begin
            chk_outs("abort_run", 0, k, vecs[1].dat[12-k], vecs[1].vld[12-k],
                     vecs[1].bsy[12-k], 1'b0);
            if (k == 2) begin
                start0 = 1'b1;
                rep = 4'd3;
            end
            if (k == 9) abort = 1'b1;
            step();
            start0 = 1'b0;
        end
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_outs("abort_idle", 0, k, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Abort while idle changes nothing: a start in the same cycle is accepted.
        abort = 1'b1;
        pulse_start(0, 4'd1);
        abort = 1'b0;
        chk_outs("abort_in_idle", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step();

        // Reset during the gap discards the transmission without a done pulse.
        pulse_start(0, 4'd2);
        for (int k = 0; k < 5; k++) step();
        chk_outs("in_gap", 0, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_outs("gap_reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_outs("gap_reset_hold", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
